// File: rtl/palette_dac_if.sv
`default_nettype none
// ============================================================================
// Module   : palette_dac_if
// Brief    : 68000-side palette window bus (select, strobes, data, DTACK).
// Revision : 1.0  initial release
// ============================================================================
interface palette_dac_if #(
   parameter int IDX_W = 13
);
   logic             cs;
   logic             cpu_rw;
   logic [IDX_W-1:0] cpu_addr;
   logic [1:0]       cpu_ds_n;
   logic [15:0]      cpu_din;
   logic [15:0]      cpu_dout;
   logic             dtack_n;

   modport master (
      output cs, cpu_rw, cpu_addr, cpu_ds_n, cpu_din,
      input  cpu_dout, dtack_n
   );

   modport slave (
      input  cs, cpu_rw, cpu_addr, cpu_ds_n, cpu_din,
      output cpu_dout, dtack_n
   );
endinterface
`default_nettype wire

// File: rtl/palette_dac.sv
`default_nettype none
// ============================================================================
// Module   : palette_dac
// Brief    : Palette lookup + RGB expansion + blanking, with CPU access to the
//            palette RAM in slots not claimed by pixel lookup.
//            Optional macro PALETTE_SHADOW_EN: halve RGB when color_in[13] set.
// Revision : 1.0  initial release
// ============================================================================
module palette_dac #(
   parameter int FORMAT = 0,
   parameter int IDX_W  = 13
) (
   input  wire              clk,
   input  wire              reset,
   input  wire              ce_pixel,
   palette_dac_if.slave     cpu,
   input  wire  [13:0]      color_in,
   input  wire              hblank_n,
   input  wire              vblank_n,
   output logic [IDX_W-1:0] ram_addr,
   output logic [15:0]      ram_din,
   output logic [1:0]       ram_we,
   input  wire  [15:0]      ram_dout,
   output logic [7:0]       red,
   output logic [7:0]       green,
   output logic [7:0]       blue,
   output logic             blank
);

   localparam logic [1:0] c_idle      = 2'd0;
   localparam logic [1:0] c_wait_slot = 2'd1;
   localparam logic [1:0] c_read_lat  = 2'd2;
   localparam logic [1:0] c_ack       = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [15:0] r_cpu_dout;
   logic        w_cpu_slot;

   logic        r_ce_d;
   logic [15:0] r_pix_word;
   logic        r_blank_s1;
   logic [7:0]  w_r_exp, w_g_exp, w_b_exp;
   logic [7:0]  w_r_fin, w_g_fin, w_b_fin;

   // ------------------------------------------------------------------------
   // CPU access FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle: begin
            if (cpu.cs) w_state_nxt = c_wait_slot;
         end
         c_wait_slot: begin
            if (!cpu.cs)
               w_state_nxt = c_idle;
            else if (!ce_pixel)
               w_state_nxt = cpu.cpu_rw ? c_read_lat : c_ack;
         end
         c_read_lat: begin
            w_state_nxt = c_ack;
         end
         c_ack: begin
            if (!cpu.cs) w_state_nxt = c_idle;
         end
         default: begin
            w_state_nxt = c_idle;
         end
      endcase
   end

   // Pixel lookup always wins the RAM port; the CPU only gets free slots.
   always_comb begin
      w_cpu_slot  = (r_state == c_wait_slot) && cpu.cs && !ce_pixel && !reset;
      ram_addr    = ce_pixel ? color_in[IDX_W-1:0] : cpu.cpu_addr;
      ram_din     = cpu.cpu_din;
      ram_we      = (w_cpu_slot && !cpu.cpu_rw) ? ~cpu.cpu_ds_n : 2'b00;
      cpu.dtack_n = (r_state != c_ack);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cpu_dout <= 16'h0000;
      end else if (r_state == c_read_lat) begin
         r_cpu_dout <= ram_dout;
      end
   end

   assign cpu.cpu_dout = r_cpu_dout;

   // ------------------------------------------------------------------------
   // Pixel pipeline: stage 1 catches the RAM word one cycle after the tick,
   // stage 2 presents it on the following tick.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ce_d     <= 1'b0;
         r_pix_word <= 16'h0000;
         r_blank_s1 <= 1'b1;
      end else begin
         r_ce_d <= ce_pixel;
         if (r_ce_d)
            r_pix_word <= ram_dout;
         if (ce_pixel)
            r_blank_s1 <= ~(hblank_n & vblank_n);
      end
   end

   generate
      if (FORMAT == 1) begin : g_fmt_555
         assign w_r_exp = {r_pix_word[14:10], r_pix_word[14:12]};
         assign w_g_exp = {r_pix_word[9:5],   r_pix_word[9:7]};
         assign w_b_exp = {r_pix_word[4:0],   r_pix_word[4:2]};
         wire w_unused_msb = r_pix_word[15];
      end else begin : g_fmt_4444
         assign w_r_exp = {r_pix_word[11:8], r_pix_word[11:8]};
         assign w_g_exp = {r_pix_word[7:4],  r_pix_word[7:4]};
         assign w_b_exp = {r_pix_word[3:0],  r_pix_word[3:0]};
         wire w_unused_top = ^r_pix_word[15:12];
      end
   endgenerate

`ifdef PALETTE_SHADOW_EN
   logic r_shadow_s1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shadow_s1 <= 1'b0;
      end else if (ce_pixel) begin
         r_shadow_s1 <= color_in[13];
      end
   end

   // Shadow darkens after expansion so both formats halve identically.
   always_comb begin
      w_r_fin = r_shadow_s1 ? {1'b0, w_r_exp[7:1]} : w_r_exp;
      w_g_fin = r_shadow_s1 ? {1'b0, w_g_exp[7:1]} : w_g_exp;
      w_b_fin = r_shadow_s1 ? {1'b0, w_b_exp[7:1]} : w_b_exp;
   end
`else
   always_comb begin
      w_r_fin = w_r_exp;
      w_g_fin = w_g_exp;
      w_b_fin = w_b_exp;
   end

   wire w_unused_shadow = color_in[13];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         red   <= 8'h00;
         green <= 8'h00;
         blue  <= 8'h00;
         blank <= 1'b1;
      end else if (ce_pixel) begin
         blank <= r_blank_s1;
         red   <= r_blank_s1 ? 8'h00 : w_r_fin;
         green <= r_blank_s1 ? 8'h00 : w_g_fin;
         blue  <= r_blank_s1 ? 8'h00 : w_b_fin;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_palette_dac.sv
`default_nettype none
// ============================================================================
// Module   : tb_palette_dac
// Brief    : Scoreboard bench: FORMAT 0 and FORMAT 1 instances on shared
//            stimulus, each with its own registered palette RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_palette_dac;
   localparam int IDX_W = 13;
`ifdef PALETTE_SHADOW_EN
   localparam bit SHADOW_EN = 1'b1;
`else
   localparam bit SHADOW_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic             ce_pixel = 1'b0;
   logic [13:0]      color_in = '0;
   logic             hblank_n = 1'b1;
   logic             vblank_n = 1'b1;
   logic [IDX_W-1:0] ram_addr0, ram_addr1;
   logic [15:0]      ram_din0, ram_din1, ram_dout0, ram_dout1;
   logic [1:0]       ram_we0, ram_we1;
   logic [7:0]       red0, green0, blue0, red1, green1, blue1;
   logic             blank0, blank1;

   palette_dac_if #(.IDX_W(IDX_W)) cpu0 ();
   palette_dac_if #(.IDX_W(IDX_W)) cpu1 ();

   assign cpu1.cs       = cpu0.cs;
   assign cpu1.cpu_rw   = cpu0.cpu_rw;
   assign cpu1.cpu_addr = cpu0.cpu_addr;
   assign cpu1.cpu_ds_n = cpu0.cpu_ds_n;
   assign cpu1.cpu_din  = cpu0.cpu_din;

   palette_dac #(.FORMAT(0), .IDX_W(IDX_W)) dut0 (
      .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .cpu(cpu0),
      .color_in(color_in), .hblank_n(hblank_n), .vblank_n(vblank_n),
      .ram_addr(ram_addr0), .ram_din(ram_din0), .ram_we(ram_we0), .ram_dout(ram_dout0),
      .red(red0), .green(green0), .blue(blue0), .blank(blank0)
   );

   palette_dac #(.FORMAT(1), .IDX_W(IDX_W)) dut1 (
      .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .cpu(cpu1),
      .color_in(color_in), .hblank_n(hblank_n), .vblank_n(vblank_n),
      .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_we(ram_we1), .ram_dout(ram_dout1),
      .red(red1), .green(green1), .blue(blue1), .blank(blank1)
   );

   // Palette RAMs: registered read (old data on same-cycle write)
   logic [15:0] mem0 [2**IDX_W];
   logic [15:0] mem1 [2**IDX_W];
   logic [15:0] ref_mem [2**IDX_W];
   logic        ram_init = 1'b1;

   function automatic logic [15:0] init_word(input int i);
      return 16'(i * 40503) ^ 16'h5A5A;
   endfunction

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 2**IDX_W; i++) mem0[i] <= init_word(i);
      end else begin
         if (ram_we0[1]) mem0[ram_addr0][15:8] <= ram_din0[15:8];
         if (ram_we0[0]) mem0[ram_addr0][7:0]  <= ram_din0[7:0];
      end
      ram_dout0 <= mem0[ram_addr0];
   end

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 2**IDX_W; i++) mem1[i] <= init_word(i);
      end else begin
         if (ram_we1[1]) mem1[ram_addr1][15:8] <= ram_din1[15:8];
         if (ram_we1[0]) mem1[ram_addr1][7:0]  <= ram_din1[7:0];
      end
      ram_dout1 <= mem1[ram_addr1];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference pixel model, output vector {blank, r, g, b}
   function automatic logic [24:0] model_px(input int fmt, input logic [15:0] e,
                                            input logic shadow, input logic blanked);
      logic [7:0] r, g, b;
      if (blanked) return {1'b1, 24'h000000};
      if (fmt == 0) begin
         r = 8'(e[11:8] * 17);
         g = 8'(e[7:4] * 17);
         b = 8'(e[3:0] * 17);
      end else begin
         r = {e[14:10], 3'b000} | 8'(e[14:10] >> 2);
         g = {e[9:5],   3'b000} | 8'(e[9:5] >> 2);
         b = {e[4:0],   3'b000} | 8'(e[4:0] >> 2);
      end
      if (SHADOW_EN && shadow) begin
         r = r >> 1;
         g = g >> 1;
         b = b >> 1;
      end
      return {1'b0, r, g, b};
   endfunction

   typedef struct {
      logic [24:0] e0;
      logic [24:0] e1;
   } sb_t;

   typedef struct {
      logic [13:0] color;
      logic        h;
      logic        v;
      bit          has_exp;
      logic [24:0] x0;
      logic [24:0] x1;
   } pst_t;

   sb_t  sb_q[$];
   pst_t pix_stim[$];
   bit   pix_en = 1'b0;
   bit   tog = 1'b0;

   // Pixel generator: one tick every other cycle while enabled
   always @(posedge clk) begin
      #1;
      if (pix_en && !tog) begin
         pst_t s;
         sb_t  x;
         tog = 1'b1;
         if (pix_stim.size() > 0) begin
            s = pix_stim.pop_front();
         end else begin
            s.color   = 14'($urandom);
            s.h       = ($urandom_range(0, 7) != 0);
            s.v       = ($urandom_range(0, 7) != 0);
            s.has_exp = 1'b0;
            s.x0      = '0;
            s.x1      = '0;
         end
         ce_pixel = 1'b1;
         color_in = s.color;
         hblank_n = s.h;
         vblank_n = s.v;
         if (s.has_exp) begin
            x.e0 = s.x0;
            x.e1 = s.x1;
         end else begin
            x.e0 = model_px(0, ref_mem[s.color[IDX_W-1:0]], s.color[13], ~(s.h & s.v));
            x.e1 = model_px(1, ref_mem[s.color[IDX_W-1:0]], s.color[13], ~(s.h & s.v));
         end
         sb_q.push_back(x);
      end else begin
         tog = 1'b0;
         ce_pixel = 1'b0;
      end
   end

   // Tick k+1 presents the pixel pushed at tick k
   always @(posedge clk) begin
      if (ce_pixel) begin
         @(negedge clk);
         if (sb_q.size() >= 2) begin
            sb_t x;
            x = sb_q.pop_front();
            check("pix_fmt0", {7'd0, blank0, red0, green0, blue0}, {7'd0, x.e0});
            check("pix_fmt1", {7'd0, blank1, red1, green1, blue1}, {7'd0, x.e1});
         end
      end
   end

   int         we_cnt = 0;
   logic [1:0] we_last = 2'b00;

   always @(negedge clk) begin
      if (ram_we0 != 2'b00) begin
         we_cnt++;
         we_last = ram_we0;
      end
      if (ce_pixel && !reset) begin
         check("own_we", {30'd0, ram_we0}, 32'd0);
         check("own_addr", {19'd0, ram_addr0}, {19'd0, color_in[IDX_W-1:0]});
      end
   end

   // align: 0 = now, 1 = on a ce cycle, 2 = on the cycle before a ce cycle
   task automatic cpu_access(input bit rw, input logic [IDX_W-1:0] addr,
                             input logic [1:0] ds_n, input logic [15:0] din,
                             input int align, input bit drop_in_wait,
                             output logic [15:0] rdata, output int lat);
      int we0;
      int guard;
      we0   = we_cnt;
      rdata = '0;
      lat   = 0;
      @(posedge clk); #2;
      guard = 0;
      while (align != 0 && ((align == 1) ? !ce_pixel : ce_pixel) && guard < 8) begin
         @(posedge clk); #2;
         guard++;
      end
      cpu0.cs       = 1'b1;
      cpu0.cpu_rw   = rw;
      cpu0.cpu_addr = addr;
      cpu0.cpu_ds_n = ds_n;
      cpu0.cpu_din  = din;
      if (drop_in_wait) begin
         @(posedge clk); #2;
         @(posedge clk); #2;
         cpu0.cs = 1'b0;
         repeat (4) begin
            @(negedge clk);
            check("drop_dtack", {31'd0, cpu0.dtack_n}, 32'd1);
         end
         check("drop_no_write", we_cnt, we0);
         return;
      end
      while (lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (!cpu0.dtack_n) break;
      end
      check("dtack_seen", {31'd0, cpu0.dtack_n}, 32'd0);
      rdata = cpu0.cpu_dout;
      @(posedge clk);
      @(negedge clk);
      check("dtack_hold", {31'd0, cpu0.dtack_n}, 32'd0);
      @(posedge clk); #2;
      cpu0.cs = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("dtack_release", {31'd0, cpu0.dtack_n}, 32'd1);
   endtask

   task automatic finish_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   initial begin
      #300000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_run();
   end

   initial begin
      logic [15:0] rd;
      int          lat;
      int          we0;
      int          guard;

      for (int i = 0; i < 2**IDX_W; i++) ref_mem[i] = init_word(i);
      cpu0.cs       = 1'b0;
      cpu0.cpu_rw   = 1'b1;
      cpu0.cpu_addr = '0;
      cpu0.cpu_ds_n = 2'b11;
      cpu0.cpu_din  = '0;

      repeat (2) @(posedge clk);
      #1 ram_init = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      repeat (2) begin
         @(negedge clk);
         check("rst_px0", {7'd0, blank0, red0, green0, blue0}, {7'd0, 1'b1, 24'h0});
         check("rst_px1", {7'd0, blank1, red1, green1, blue1}, {7'd0, 1'b1, 24'h0});
         check("rst_dtack", {31'd0, cpu0.dtack_n}, 32'd1);
         check("rst_we", {30'd0, ram_we0}, 32'd0);
         check("rst_dout", {16'd0, cpu0.cpu_dout}, 32'd0);
      end

      // Word write then readback
      we0 = we_cnt;
      cpu_access(1'b0, 13'h0123, 2'b00, 16'h0F84, 0, 1'b0, rd, lat);
      ref_mem[13'h0123] = 16'h0F84;
      check("wr_we_cycles", we_cnt - we0, 1);
      check("wr_we_val", {30'd0, we_last}, 32'd3);
      check("wr_lat", {31'd0, lat <= 4}, 32'd1);
      cpu_access(1'b1, 13'h0123, 2'b00, 16'h0000, 0, 1'b0, rd, lat);
      check("rd_word", {16'd0, rd}, 32'h0F84);
      check("rd_lat", {31'd0, lat <= 4}, 32'd1);

      // Lower-byte write
      we0 = we_cnt;
      cpu_access(1'b0, 13'h0123, 2'b10, 16'hAB55, 0, 1'b0, rd, lat);
      ref_mem[13'h0123][7:0] = 8'h55;
      check("bw_we_cycles", we_cnt - we0, 1);
      check("bw_we_val", {30'd0, we_last}, 32'd1);
      cpu_access(1'b1, 13'h0123, 2'b00, 16'h0000, 0, 1'b0, rd, lat);
      check("bw_rd0", {16'd0, rd}, 32'h0F55);
      check("bw_rd1", {16'd0, cpu1.cpu_dout}, 32'h0F55);

      // Palette contents for the pixel checks
      cpu_access(1'b0, 13'h0123, 2'b00, 16'h0F84, 0, 1'b0, rd, lat);
      ref_mem[13'h0123] = 16'h0F84;
      cpu_access(1'b0, 13'h0456, 2'b00, 16'h7FFF, 0, 1'b0, rd, lat);
      ref_mem[13'h0456] = 16'h7FFF;

      pix_stim.push_back('{14'h0123, 1'b1, 1'b1, 1'b1, {1'b0, 24'hFF8844}, {1'b0, 24'h18E721}});
      pix_stim.push_back('{14'h0123, 1'b0, 1'b1, 1'b1, {1'b1, 24'h0}, {1'b1, 24'h0}});
      pix_stim.push_back('{14'h2456, 1'b1, 1'b1, 1'b1,
                           SHADOW_EN ? {1'b0, 24'h7F7F7F} : {1'b0, 24'hFFFFFF},
                           SHADOW_EN ? {1'b0, 24'h7F7F7F} : {1'b0, 24'hFFFFFF}});
      pix_stim.push_back('{14'h0123, 1'b1, 1'b0, 1'b1, {1'b1, 24'h0}, {1'b1, 24'h0}});
      pix_stim.push_back('{14'h0456, 1'b1, 1'b1, 1'b1, {1'b0, 24'hFFFFFF}, {1'b0, 24'hFFFFFF}});
      pix_en = 1'b1;
      guard = 0;
      while (pix_stim.size() != 0 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      check("stim_drain", pix_stim.size(), 0);
      repeat (40) @(posedge clk);

      // Contention with the running pixel stream
      cpu_access(1'b1, 13'h0123, 2'b00, 16'h0000, 1, 1'b0, rd, lat);
      check("ct_rd_ce", {16'd0, rd}, 32'h0F84);
      check("ct_lat_ce", {31'd0, lat <= 4}, 32'd1);
      cpu_access(1'b1, 13'h0456, 2'b00, 16'h0000, 2, 1'b0, rd, lat);
      check("ct_rd_pre", {16'd0, rd}, 32'h7FFF);
      check("ct_lat_pre", {31'd0, lat <= 4}, 32'd1);
      cpu_access(1'b0, 13'h0123, 2'b00, 16'hDEAD, 2, 1'b1, rd, lat);
      cpu_access(1'b1, 13'h0123, 2'b00, 16'h0000, 0, 1'b0, rd, lat);
      check("ct_after_drop", {16'd0, rd}, 32'h0F84);
      we0 = we_cnt;
      cpu_access(1'b0, 13'h0456, 2'b11, 16'h0000, 1, 1'b0, rd, lat);
      check("nostrobe_we", we_cnt - we0, 0);
      cpu_access(1'b1, 13'h0456, 2'b00, 16'h0000, 1, 1'b0, rd, lat);
      check("nostrobe_rd", {16'd0, rd}, 32'h7FFF);
      repeat (30) @(posedge clk);

      #1 pix_en = 1'b0;
      repeat (4) @(posedge clk);
      sb_q.delete();
      finish_run();
   end

endmodule
`default_nettype wire
